// File: rtl/run_ctrl_pkg.sv
// Shared types and sizing helpers for the core run controller.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      RUN,
      DONE
   } run_state_t;

   localparam int DROP_W   = 8;
   localparam int DROP_MAX = 255;

   // Index width for n items, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Host/core facing bundle of the run controller; master drives stimulus, slave is the controller.
interface core_run_ctrl_if
   import run_ctrl_pkg::*;
#(
   parameter int NCORES = 1,
   parameter int XLEN   = 32,
   parameter int CNT_W  = 16
);

   localparam int IDX_W = idx_width(NCORES);

   logic                     start;
   logic [NCORES-1:0]        core_trap;
   logic [NCORES-1:0]        core_step;
   logic [NCORES*XLEN-1:0]   core_result;
   logic [NCORES-1:0]        core_resetn;
   logic [NCORES*XLEN-1:0]   result;
   logic [NCORES-1:0]        trap_seen;
   logic [CNT_W-1:0]         cycle_count;
   logic                     done;
   logic                     timed_out;
   logic                     trace_valid;
   logic [IDX_W-1:0]         trace_core;
   logic [DROP_W-1:0]        trace_dropped;

   modport master (
      output start, core_trap, core_step, core_result,
      input  core_resetn, result, trap_seen, cycle_count, done, timed_out,
             trace_valid, trace_core, trace_dropped
   );

   modport slave (
      input  start, core_trap, core_step, core_result,
      output core_resetn, result, trap_seen, cycle_count, done, timed_out,
             trace_valid, trace_core, trace_dropped
   );

endinterface

// File: rtl/trap_capture.sv
// Per-core trap edge detector with sticky seen flag and result latch.
module trap_capture #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            arm,
   input  logic            run_en,
   input  logic            trap,
   input  logic [XLEN-1:0] data,
   output logic            seen,
   output logic            hit,
   output logic [XLEN-1:0] held
);

   logic trap_q;

   assign hit = run_en & trap & ~trap_q & ~seen;

   // trap_q follows the trap level every cycle, so a trap already high at start never counts as an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trap_q <= 1'b0;
         seen   <= 1'b0;
         held   <= '0;
      end else begin
         trap_q <= trap;
         if (arm) begin
            seen <= 1'b0;
            held <= '0;
         end else if (hit) begin
            seen <= 1'b1;
            held <= data;
         end
      end
   end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: sequences core reset, counts run cycles, captures traps, enforces a watchdog, emits trace strobes.
module core_run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int NCORES         = 1,
   parameter int XLEN           = 32,
   parameter int RESET_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int CNT_W          = 16
) (
   input logic            clk,
   input logic            reset,
   core_run_ctrl_if.slave bus
);

   localparam int IDX_W  = idx_width(NCORES);
   localparam int HOLD_W = idx_width(RESET_CYCLES);
   localparam int POP_W  = $clog2(NCORES + 1);
   localparam int SUM_W  = DROP_W + POP_W;

   run_state_t state, next_state;

   logic                   accept;
   logic                   run_en;
   logic                   in_hold;
   logic                   hold_last;
   logic                   all_trapped;
   logic                   watchdog;
   logic [NCORES-1:0]      seen;
   logic [NCORES-1:0]      hits;
   logic [NCORES-1:0]      req;
   logic [NCORES*XLEN-1:0] held;
   logic [HOLD_W-1:0]      hold_cnt;
   logic [IDX_W-1:0]       req_idx;
   logic                   req_any;
   logic [POP_W-1:0]       req_cnt;
   logic [SUM_W-1:0]       drop_sum;
   logic [DROP_W-1:0]      drop_next;

   for (genvar i = 0; i < NCORES; i++) begin : g_cap
      trap_capture #(.XLEN(XLEN)) u_cap (
         .clk    (clk),
         .reset  (reset),
         .arm    (accept),
         .run_en (run_en),
         .trap   (bus.core_trap[i]),
         .data   (bus.core_result[i*XLEN +: XLEN]),
         .seen   (seen[i]),
         .hit    (hits[i]),
         .held   (held[i*XLEN +: XLEN])
      );
   end

   assign bus.result    = held;
   assign bus.trap_seen = seen;

   assign hold_last   = (hold_cnt == HOLD_W'(RESET_CYCLES - 1));
   assign all_trapped = &(seen | hits);
   assign watchdog    = (bus.cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: if (bus.start)                next_state = HOLD;
         HOLD:       if (hold_last)                next_state = RUN;
         RUN:        if (all_trapped || watchdog)  next_state = DONE;
         default:                                  next_state = IDLE;
      endcase
   end

   always_comb begin
      accept  = bus.start && ((state == IDLE) || (state == DONE));
      run_en  = (state == RUN);
      in_hold = (state == HOLD);
   end

   // A core leaves reset only while running and untrapped; a trap this cycle parks it from the next.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.core_resetn <= '0;
         hold_cnt        <= '0;
         bus.cycle_count <= '0;
         bus.done        <= 1'b0;
         bus.timed_out   <= 1'b0;
      end else begin
         bus.core_resetn <= (next_state == RUN) ? ~(seen | hits) : '0;
         if (accept) begin
            hold_cnt        <= '0;
            bus.cycle_count <= '0;
            bus.done        <= 1'b0;
            bus.timed_out   <= 1'b0;
         end else begin
            if (in_hold) hold_cnt <= hold_cnt + HOLD_W'(1);
            if (run_en) begin
               if (bus.cycle_count != '1) bus.cycle_count <= bus.cycle_count + CNT_W'(1);
               if (all_trapped) begin
                  bus.done <= 1'b1;
               end else if (watchdog) begin
                  bus.done      <= 1'b1;
                  bus.timed_out <= 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      req     = bus.core_step & ~seen;
      req_any = |req;
      req_idx = '0;
      req_cnt = '0;
      for (int i = NCORES - 1; i >= 0; i--) begin
         if (req[i]) req_idx = IDX_W'(i);
      end
      for (int i = 0; i < NCORES; i++) begin
         req_cnt = req_cnt + POP_W'(req[i]);
      end
      drop_sum  = SUM_W'(bus.trace_dropped) + SUM_W'(req_cnt) - SUM_W'(1);
      drop_next = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_W'(DROP_MAX) : drop_sum[DROP_W-1:0];
   end

   // Winner gets the strobe; every other simultaneous requester is tallied as dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.trace_valid   <= 1'b0;
         bus.trace_core    <= '0;
         bus.trace_dropped <= '0;
      end else begin
         bus.trace_valid <= run_en & req_any;
         if (run_en && req_any) bus.trace_core <= req_idx;
         if (accept)                  bus.trace_dropped <= '0;
         else if (run_en && req_any)  bus.trace_dropped <= drop_next;
      end
   end

endmodule
